// File: rtl/bit_framer_pkg.sv
// Shared types and defaults for the bit-pair framer.
// State encoding plus the default sync pattern and limits.
package bit_framer_pkg;

   typedef enum logic [1:0] {
      HUNT,
      ORDER,
      BIT1,
      BIT2
   } state_t;

   localparam int SYNC_LEN_DEF = 4;
   localparam logic [3:0] SYNC_WORD_DEF = 4'b1011;
   localparam int FRAMES_DEF = 4;
   localparam int TIMEOUT_DEF = 8;

endpackage

// File: rtl/bit_pair_framer_if.sv
// Serial input and framed output bundle for the bit-pair framer.
// The master side drives the serial stream and observes frames.
interface bit_pair_framer_if;

   logic serial_in;
   logic serial_valid;
   logic data1;
   logic data2;
   logic order;
   logic pair_valid;
   logic locked;
   logic frame_err;

   modport master (
      output serial_in,
      output serial_valid,
      input  data1,
      input  data2,
      input  order,
      input  pair_valid,
      input  locked,
      input  frame_err
   );

   modport slave (
      input  serial_in,
      input  serial_valid,
      output data1,
      output data2,
      output order,
      output pair_valid,
      output locked,
      output frame_err
   );

endinterface

// File: rtl/sync_detector.sv
// Sync pattern detector: bit history plus comparator.
// The history is held at zero while clear is high.
module sync_detector #(
   parameter int SYNC_LEN = 4,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD = 4'b1011
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic shift,
   input  logic bit_in,
   output logic match
);

   logic [SYNC_LEN-2:0] hist;
   logic [SYNC_LEN-1:0] nxt;

   assign nxt   = {hist, bit_in};
   assign match = shift && (nxt == SYNC_WORD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
      end else if (clear) begin
         hist <= '0;
      end else if (shift) begin
         hist <= nxt[SYNC_LEN-2:0];
      end
   end

endmodule

// File: rtl/bit_pair_framer.sv
// Serial framer: hunts for a sync word, then emits
// FRAMES frames of {order, data1, data2}.
module bit_pair_framer
   import bit_framer_pkg::*;
#(
   parameter int SYNC_LEN = SYNC_LEN_DEF,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter int FRAMES = FRAMES_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic clk,
   input logic reset,
   bit_pair_framer_if.slave bus
);

   state_t state;
   logic   ord_r;
   logic   b1_r;
   logic   order_q;
   logic   d1_q;
   logic   d2_q;
   logic   pv_q;
   logic   lk_q;
   logic   fe_q;
   logic [7:0] idle;
   logic [7:0] fcnt;
   logic   hunting;
   logic   match;

   assign hunting = (state == HUNT);

   sync_detector #(
      .SYNC_LEN (SYNC_LEN),
      .SYNC_WORD(SYNC_WORD)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .clear (!hunting),
      .shift (hunting && bus.serial_valid),
      .bit_in(bus.serial_in),
      .match (match)
   );

   assign bus.order      = order_q;
   assign bus.data1      = d1_q;
   assign bus.data2      = d2_q;
   assign bus.pair_valid = pv_q;
   assign bus.locked     = lk_q;
   assign bus.frame_err  = fe_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= HUNT;
         ord_r   <= 1'b0;
         b1_r    <= 1'b0;
         order_q <= 1'b0;
         d1_q    <= 1'b0;
         d2_q    <= 1'b0;
         pv_q    <= 1'b0;
         lk_q    <= 1'b0;
         fe_q    <= 1'b0;
         idle    <= '0;
         fcnt    <= '0;
      end else begin
         pv_q <= 1'b0;
         fe_q <= 1'b0;
         unique case (state)
            HUNT: begin
               idle <= '0;
               if (match) begin
                  state <= ORDER;
                  lk_q  <= 1'b1;
               end
            end
            ORDER, BIT1, BIT2: begin
               if (bus.serial_valid) begin
                  idle <= '0;
                  if (state == ORDER) begin
                     ord_r <= bus.serial_in;
                     state <= BIT1;
                  end else if (state == BIT1) begin
                     b1_r  <= bus.serial_in;
                     state <= BIT2;
                  end else begin
                     order_q <= ord_r;
                     d1_q    <= b1_r;
                     d2_q    <= bus.serial_in;
                     pv_q    <= 1'b1;
                     if (fcnt == 8'(FRAMES - 1)) begin
                        fcnt  <= '0;
                        state <= HUNT;
                        lk_q  <= 1'b0;
                     end else begin
                        fcnt  <= fcnt + 8'd1;
                        state <= ORDER;
                     end
                  end
               end else if (idle == 8'(TIMEOUT - 1)) begin
                  // abort on the TIMEOUT-th consecutive idle cycle
                  state <= HUNT;
                  lk_q  <= 1'b0;
                  fe_q  <= 1'b1;
                  idle  <= '0;
                  fcnt  <= '0;
               end else if (idle != 8'(TIMEOUT)) begin
                  idle <= idle + 8'd1;
               end
            end
            default: state <= HUNT;
         endcase
      end
   end

endmodule

// File: tb/tb_bit_pair_framer.sv
// Randomized and directed bench for bit_pair_framer
// against a queue-based reference model.
module tb_bit_pair_framer;

   localparam int SL = 4;
   localparam logic [SL-1:0] SW = 4'b1011;
   localparam int FR = 4;
   localparam int TO = 8;

   logic clk;
   logic reset;

   bit_pair_framer_if bus ();

   bit_pair_framer #(
      .SYNC_LEN (SL),
      .SYNC_WORD(SW),
      .FRAMES   (FR),
      .TIMEOUT  (TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_pass;

   bit hq[$];
   bit fq[$];
   bit m_locked;
   bit m_ord;
   bit m_d1;
   bit m_d2;
   bit m_pv;
   bit m_fe;
   int m_idle;
   int m_frames;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
   endtask

   task automatic hunt_reset();
      hq = {};
      for (int i = 0; i < SL - 1; i++) hq.push_back(1'b0);
   endtask

   task automatic model_reset();
      hunt_reset();
      fq = {};
      m_locked = 0;
      m_ord = 0;
      m_d1 = 0;
      m_d2 = 0;
      m_pv = 0;
      m_fe = 0;
      m_idle = 0;
      m_frames = 0;
   endtask

   function automatic bit hist_match();
      logic [SL-1:0] w;
      w = '0;
      for (int i = 0; i < SL; i++) w = {w[SL-2:0], hq[i]};
      return (hq.size() == SL) && (w == SW);
   endfunction

   task automatic model(input bit v, input bit b);
      m_pv = 0;
      m_fe = 0;
      if (!m_locked) begin
         m_idle = 0;
         if (v) begin
            hq.push_back(b);
            if (hq.size() > SL) void'(hq.pop_front());
            if (hist_match()) begin
               m_locked = 1;
               fq = {};
               m_frames = 0;
            end
         end
      end else if (v) begin
         m_idle = 0;
         fq.push_back(b);
         if (fq.size() == 3) begin
            m_ord = fq[0];
            m_d1 = fq[1];
            m_d2 = fq[2];
            m_pv = 1;
            fq = {};
            m_frames++;
            if (m_frames == FR) begin
               m_locked = 0;
               m_frames = 0;
               hunt_reset();
            end
         end
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            m_locked = 0;
            m_fe = 1;
            m_idle = 0;
            m_frames = 0;
            fq = {};
            hunt_reset();
         end
      end
   endtask

   task automatic compare();
      chk("locked", bus.locked, m_locked);
      chk("pair_valid", bus.pair_valid, m_pv);
      chk("frame_err", bus.frame_err, m_fe);
      chk("data", {bus.order, bus.data1, bus.data2}, {m_ord, m_d1, m_d2});
   endtask

   task automatic step(input bit v, input bit b);
      bus.serial_valid = v;
      bus.serial_in = b;
      @(posedge clk);
      model(v, b);
      @(negedge clk);
      compare();
   endtask

   task automatic bits(input logic [15:0] pat, input int n);
      for (int i = n - 1; i >= 0; i--) step(1'b1, pat[i]);
   endtask

   task automatic idles(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic async_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_out", {bus.locked, bus.pair_valid, bus.frame_err,
                      bus.order, bus.data1, bus.data2}, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      chk("rst_hold", {bus.locked, bus.pair_valid, bus.frame_err,
                       bus.order, bus.data1, bus.data2}, 8'h00);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      reset = 1'b1;
      bus.serial_in = 1'b0;
      bus.serial_valid = 1'b0;
      model_reset();
      #1;
      chk("reset_state", {bus.locked, bus.pair_valid, bus.frame_err,
                          bus.order, bus.data1, bus.data2}, 8'h00);
      @(negedge clk);
      reset = 1'b0;

      bits(16'b1011, 4);
      chk("lock_after_sync", bus.locked, 1'b1);
      bits(16'b010, 3);
      chk("first_pair", {bus.pair_valid, bus.order, bus.data1, bus.data2},
          8'b1010);

      // partial frame then reset: no pulses may escape
      bits(16'b1, 1);
      async_reset();
      idles(2);

      bits(16'b1011, 4);
      bits(16'b110_001_100_011, 12);
      chk("unlock_after_frames", bus.locked, 1'b0);
      chk("last_frame", {bus.order, bus.data1, bus.data2}, 8'b011);
      bits(16'b011, 3);
      chk("no_pulse_hunting", bus.pair_valid, 1'b0);

      bits(16'b1011, 4);
      bits(16'b1, 1);
      idles(7);
      chk("no_err_early", bus.frame_err, 1'b0);
      idles(1);
      chk("timeout_err", bus.frame_err, 1'b1);
      chk("timeout_data", {bus.order, bus.data1, bus.data2}, 8'b011);

      bits(16'b1011, 4);
      bits(16'b1, 1);
      idles(7);
      bits(16'b0, 1);
      idles(7);
      bits(16'b1, 1);
      chk("gap_pair", {bus.pair_valid, bus.frame_err, bus.order,
                       bus.data1, bus.data2}, 8'b10101);

      async_reset();
      bits(16'b1101, 4);
      chk("no_lock_4", bus.locked, 1'b0);
      bits(16'b1, 1);
      chk("lock_5th", bus.locked, 1'b1);

      for (int i = 0; i < 1500; i++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r == 0) idles($urandom_range(6, 10));
         else step(r < 15, 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
